// File: rtl/saturn_bus_daisy_ctrl_pkg.sv
// Shared definitions for the Saturn bus daisy-chain controller: command
// encodings, controller state encoding and the per-position module ID table.
package saturn_bus_daisy_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_CONFIG = 2'd0,
        CMD_UNCNFG = 2'd1,
        CMD_RESET  = 2'd2,
        CMD_C_ID   = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // IDs reported by C_ID for chain positions 0 (mmio), 1 (sysram), 2 (rom)
    localparam logic [19:0] ID_MMIO   = 20'h00019;
    localparam logic [19:0] ID_SYSRAM = 20'h000F4;
    localparam logic [19:0] ID_ROM    = 20'h000F6;

    function automatic logic [19:0] module_id(input int unsigned idx);
        case (idx)
            0:       return ID_MMIO;
            1:       return ID_SYSRAM;
            2:       return ID_ROM;
            default: return 20'h00000;
        endcase
    endfunction

endpackage

// File: rtl/saturn_bus_addr_match.sv
// Per-module mask/base compare: one against the live bus address and one
// against the latched command operand (used to find the UNCNFG target).
module saturn_bus_addr_match #(
    parameter int ADDR_W = 20
) (
    input  logic              i_configured,
    input  logic [ADDR_W-1:0] i_mask,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    output logic              o_hit,
    output logic              o_cmd_hit
);

    assign o_hit     = i_configured && ((i_addr & i_mask) == i_base);
    assign o_cmd_hit = i_configured && ((i_cmd_addr & i_mask) == i_base);

endmodule

// File: rtl/saturn_bus_daisy_ctrl.sv
// Saturn bus daisy-chain configuration controller with live address decode.
// Optional overlap detection enabled by defining SATURN_DAISY_OVERLAP_CHECK_EN.
module saturn_bus_daisy_ctrl
    import saturn_bus_daisy_ctrl_pkg::*;
#(
    parameter int NUM_MODULES = 3,
    parameter int ADDR_W      = 20
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clk_en,
    input  logic                   i_cmd_valid,
    input  logic [1:0]             i_cmd,
    input  logic [ADDR_W-1:0]      i_cmd_addr,
    output logic                   o_cmd_ready,
    output logic                   o_id_valid,
    output logic [ADDR_W-1:0]      o_id,
    output logic                   o_cmd_err,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [NUM_MODULES-1:0] o_sel,
    output logic [NUM_MODULES-1:0] o_daisy,
    output logic                   o_overlap_err,
    output state_t                 o_dbg_state
);

    localparam int IDX_W = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;

    // Command handshake: a command transfers on an enabled cycle where
    // i_cmd_valid and o_cmd_ready are both high; ready is high only in IDLE.
    state_t                               state_q, state_d;
    cmd_t                                 cmd_q;
    logic [ADDR_W-1:0]                    cmd_addr_q;
    logic [NUM_MODULES-1:0]               configured_q, size_set_q;
    logic [NUM_MODULES-1:0][ADDR_W-1:0]   mask_q, base_q;
    logic [ADDR_W-1:0]                    id_q;
    logic                                 resp_id_q, resp_err_q;
    logic [NUM_MODULES-1:0]               hit, cmd_hit;
    logic                                 unc_found, cmd_found;
    logic [IDX_W-1:0]                     unc_idx, cmd_idx;
    logic                                 accept;

    for (genvar k = 0; k < NUM_MODULES; k++) begin : g_match
        saturn_bus_addr_match #(.ADDR_W(ADDR_W)) u_match (
            .i_configured (configured_q[k]),
            .i_mask       (mask_q[k]),
            .i_base       (base_q[k]),
            .i_addr       (i_addr),
            .i_cmd_addr   (cmd_addr_q),
            .o_hit        (hit[k]),
            .o_cmd_hit    (cmd_hit[k])
        );
    end

    assign accept = i_clk_en && i_cmd_valid && (state_q == ST_IDLE);

    // Lowest unconfigured module is the CONFIG / C_ID target
    always_comb begin
        unc_found = 1'b0;
        unc_idx   = '0;
        for (int k = NUM_MODULES - 1; k >= 0; k--) begin
            if (!configured_q[k]) begin
                unc_found = 1'b1;
                unc_idx   = IDX_W'(k);
            end
        end
    end

    // Highest configured module matching the operand is the UNCNFG target
    always_comb begin
        cmd_found = 1'b0;
        cmd_idx   = '0;
        for (int k = 0; k < NUM_MODULES; k++) begin
            if (cmd_hit[k]) begin
                cmd_found = 1'b1;
                cmd_idx   = IDX_W'(k);
            end
        end
    end

    always_comb begin
        o_sel = '0;
        for (int k = 0; k < NUM_MODULES; k++) begin
            if (hit[k]) begin
                o_sel    = '0;
                o_sel[k] = 1'b1;
            end
        end
    end

`ifdef SATURN_DAISY_OVERLAP_CHECK_EN
    assign o_overlap_err = |(hit & (hit - NUM_MODULES'(1)));
`else
    assign o_overlap_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else if (i_clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_cmd_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = (state_q == ST_IDLE);
        o_id_valid  = (state_q == ST_RESP) && resp_id_q;
        o_cmd_err   = (state_q == ST_RESP) && resp_err_q;
        o_dbg_state = state_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cmd_q        <= CMD_CONFIG;
            cmd_addr_q   <= '0;
            configured_q <= '0;
            size_set_q   <= '0;
            mask_q       <= '0;
            base_q       <= '0;
            id_q         <= '0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else if (accept) begin
            cmd_q      <= cmd_t'(i_cmd);
            cmd_addr_q <= i_cmd_addr;
        end else if (i_clk_en && state_q == ST_EXEC) begin
            resp_id_q  <= 1'b0;
            resp_err_q <= 1'b0;
            case (cmd_q)
                CMD_CONFIG: begin
                    if (!unc_found) begin
                        resp_err_q <= 1'b1;
                    end else if (!size_set_q[unc_idx]) begin
                        mask_q[unc_idx]     <= cmd_addr_q;
                        size_set_q[unc_idx] <= 1'b1;
                    end else begin
                        base_q[unc_idx]       <= cmd_addr_q & mask_q[unc_idx];
                        configured_q[unc_idx] <= 1'b1;
                        size_set_q[unc_idx]   <= 1'b0;
                    end
                end
                CMD_UNCNFG: begin
                    if (cmd_found) begin
                        configured_q[cmd_idx] <= 1'b0;
                        size_set_q[cmd_idx]   <= 1'b0;
                    end else begin
                        resp_err_q <= 1'b1;
                    end
                end
                CMD_RESET: begin
                    configured_q <= '0;
                    size_set_q   <= '0;
                end
                CMD_C_ID: begin
                    id_q      <= unc_found ? ADDR_W'(module_id(32'(unc_idx))) : '0;
                    resp_id_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_daisy = configured_q;
    assign o_id    = id_q;

endmodule
